// File: rtl/alien_fleet.sv
// Alien fleet opponent: marches a ROWS x COLS grid across the 32x16 playfield and resolves bullet hits.
// Optional macro SPEEDUP_EN makes the march period track the number of live aliens.
module alien_fleet #(
  parameter int ROWS     = 4,
  parameter int COLS     = 8,
  parameter int MOVE_DIV = 8,
  parameter int LAND_ROW = 13,
  localparam int CNT_W   = $clog2(ROWS*COLS+1)
) (
  input  logic                 clk_36MHz,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 clear,
  input  logic [4:0]           bullet_x,
  input  logic [3:0]           bullet_y,
  input  logic                 bullet_flying,
  output logic                 hit,
  output logic [ROWS*COLS-1:0] alive_map,
  output logic [CNT_W-1:0]     alive_count,
  output logic [4:0]           fleet_x,
  output logic [3:0]           fleet_y,
  output logic                 fleet_cleared,
  output logic                 invaded
);

  localparam int N     = ROWS*COLS;
  localparam int W     = 2*COLS-1;
  localparam int IDX_W = $clog2(N);
  localparam int DIV_W = ($clog2(MOVE_DIV+1) > CNT_W) ? $clog2(MOVE_DIV+1) : CNT_W;
  localparam logic [4:0] XMAX  = 5'(32-W);
  localparam logic [4:0] W_M1  = 5'(W-1);
  localparam logic [4:0] ROWS5 = 5'(ROWS);
  localparam logic [4:0] LAND5 = 5'(LAND_ROW);

  typedef enum logic [1:0] {IDLE, MARCH, CLEARED, LANDED} state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      alive_map_q, alive_map_d;
  logic [CNT_W-1:0]  alive_count_q, alive_count_d;
  logic [4:0]        fleet_x_q, fleet_x_d;
  logic [3:0]        fleet_y_q, fleet_y_d;
  logic              dir_left_q, dir_left_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              hit_q, hit_d;

  logic [4:0]        dx;
  logic [3:0]        dy;
  logic              candidate;
  logic [IDX_W-1:0]  kill_idx;
  logic [DIV_W-1:0]  period;
  logic              landed;

  always_ff @(posedge clk_36MHz or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      alive_map_q   <= '1;
      alive_count_q <= CNT_W'(N);
      fleet_x_q     <= '0;
      fleet_y_q     <= '0;
      dir_left_q    <= 1'b0;
      div_q         <= '0;
      hit_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      alive_map_q   <= alive_map_d;
      alive_count_q <= alive_count_d;
      fleet_x_q     <= fleet_x_d;
      fleet_y_q     <= fleet_y_d;
      dir_left_q    <= dir_left_d;
      div_q         <= div_d;
      hit_q         <= hit_d;
    end
  end

  // Bullet offset from the fleet origin; the >= guards reject positions left of or above the fleet.
  always_comb begin
    dx        = bullet_x - fleet_x_q;
    dy        = bullet_y - fleet_y_q;
    candidate = bullet_flying && (bullet_x >= fleet_x_q) && (dx <= W_M1) && !dx[0] &&
                (bullet_y >= fleet_y_q) && ({1'b0, dy} < ROWS5);
    kill_idx  = IDX_W'(dy) * IDX_W'(COLS) + IDX_W'(dx[4:1]);
  end

  always_comb begin
    landed = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (|alive_map_q[r*COLS +: COLS] && (({1'b0, fleet_y_q} + 5'(r)) >= LAND5)) landed = 1'b1;
    end
  end

  always_comb begin
`ifdef SPEEDUP_EN
    period = (alive_count_q == '0) ? DIV_W'(1) : DIV_W'(alive_count_q);
`else
    period = DIV_W'(MOVE_DIV);
`endif
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = MARCH;
        MARCH: begin
          if (alive_count_q == '0) state_d = CLEARED;
          else if (landed)         state_d = LANDED;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    fleet_cleared = (state_q == CLEARED);
    invaded       = (state_q == LANDED);
  end

  // Kill and march both act on the pre-step position, so they can happen on the same edge.
  always_comb begin
    alive_map_d   = alive_map_q;
    alive_count_d = alive_count_q;
    fleet_x_d     = fleet_x_q;
    fleet_y_d     = fleet_y_q;
    dir_left_d    = dir_left_q;
    div_d         = div_q;
    hit_d         = 1'b0;
    if (clear) begin
      alive_map_d   = '1;
      alive_count_d = CNT_W'(N);
      fleet_x_d     = '0;
      fleet_y_d     = '0;
      dir_left_d    = 1'b0;
      div_d         = '0;
    end else if (state_q == MARCH) begin
      if (candidate && alive_map_q[kill_idx]) begin
        hit_d                 = 1'b1;
        alive_map_d[kill_idx] = 1'b0;
        alive_count_d         = alive_count_q - 1'b1;
      end
      if (enable) begin
        if (div_q >= period - 1'b1) begin
          div_d = '0;
          if (!dir_left_q && fleet_x_q < XMAX) begin
            fleet_x_d = fleet_x_q + 1'b1;
          end else if (dir_left_q && fleet_x_q != '0) begin
            fleet_x_d = fleet_x_q - 1'b1;
          end else begin
            if (fleet_y_q != 4'd15) fleet_y_d = fleet_y_q + 1'b1;
            dir_left_d = !dir_left_q;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
    end
  end

  assign hit         = hit_q;
  assign alive_map   = alive_map_q;
  assign alive_count = alive_count_q;
  assign fleet_x     = fleet_x_q;
  assign fleet_y     = fleet_y_q;

endmodule

// File: tb/tb_alien_fleet.sv
// Directed self-checking bench for alien_fleet (MOVE_DIV overridden to 4 to shorten marches).
module tb_alien_fleet;

  logic        clk_36MHz;
  logic        reset;
  logic        enable;
  logic        start;
  logic        clear;
  logic [4:0]  bullet_x;
  logic [3:0]  bullet_y;
  logic        bullet_flying;
  logic        hit;
  logic [31:0] alive_map;
  logic [5:0]  alive_count;
  logic [4:0]  fleet_x;
  logic [3:0]  fleet_y;
  logic        fleet_cleared;
  logic        invaded;

  int checks = 0;
  int errors = 0;

  alien_fleet #(.ROWS(4), .COLS(8), .MOVE_DIV(4), .LAND_ROW(13)) dut (
    .clk_36MHz(clk_36MHz),
    .reset(reset),
    .enable(enable),
    .start(start),
    .clear(clear),
    .bullet_x(bullet_x),
    .bullet_y(bullet_y),
    .bullet_flying(bullet_flying),
    .hit(hit),
    .alive_map(alive_map),
    .alive_count(alive_count),
    .fleet_x(fleet_x),
    .fleet_y(fleet_y),
    .fleet_cleared(fleet_cleared),
    .invaded(invaded)
  );

  initial begin
    clk_36MHz = 1'b0;
    forever #5 clk_36MHz = ~clk_36MHz;
  end

  task automatic tick();
    @(posedge clk_36MHz);
    #1;
  endtask

  task automatic run_enable(input int n);
    enable = 1'b1;
    repeat (n) tick();
    enable = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [4:0] x, input logic [3:0] y, input logic fly);
    bullet_x      = x;
    bullet_y      = y;
    bullet_flying = fly;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; start = 1'b0; enable = 1'b0;
    apply_stimulus(5'd0, 4'd0, 1'b0);
    repeat (2) tick();
    check_output("rst_count", 32'(alive_count), 32'd32);
    check_output("rst_map", alive_map, 32'hFFFF_FFFF);
    check_output("rst_x", 32'(fleet_x), 32'd0);
    check_output("rst_hit", 32'(hit), 32'd0);
    check_output("rst_flags", {30'd0, fleet_cleared, invaded}, 32'd0);
    reset = 1'b0;
    tick();

    // IDLE ignores bullets
    apply_stimulus(5'd0, 4'd0, 1'b1);
    tick();
    check_output("idle_nohit", 32'(hit), 32'd0);
    apply_stimulus(5'd0, 4'd0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;

    apply_stimulus(5'd4, 4'd2, 1'b1);
    tick();
    check_output("hit_42", 32'(hit), 32'd1);
    check_output("map18", 32'(alive_map[18]), 32'd0);
    check_output("count31", 32'(alive_count), 32'd31);
    tick();
    check_output("held_nohit", 32'(hit), 32'd0);
    check_output("held_count", 32'(alive_count), 32'd31);
    apply_stimulus(5'd5, 4'd2, 1'b1); tick();
    check_output("odd_dx", 32'(hit), 32'd0);
    apply_stimulus(5'd4, 4'd4, 1'b1); tick();
    check_output("dy_out", 32'(hit), 32'd0);
    apply_stimulus(5'd6, 4'd2, 1'b0); tick();
    check_output("not_flying", 32'(hit), 32'd0);
    check_output("map19", 32'(alive_map[19]), 32'd1);

    run_enable(4);
    check_output("step1_x", 32'(fleet_x), 32'd1);
    check_output("step1_y", 32'(fleet_y), 32'd0);
    run_enable(16*4);
    check_output("step17_x", 32'(fleet_x), 32'd17);
    check_output("step17_y", 32'(fleet_y), 32'd0);
    run_enable(4);
    check_output("step18_x", 32'(fleet_x), 32'd17);
    check_output("step18_y", 32'(fleet_y), 32'd1);
    run_enable(4);
    check_output("step19_x", 32'(fleet_x), 32'd16);

    // Fleet origin now (16,1)
    apply_stimulus(5'd15, 4'd1, 1'b1); tick();
    check_output("left_of_fleet", 32'(hit), 32'd0);
    apply_stimulus(5'd30, 4'd4, 1'b1); tick();
    check_output("far_corner_hit", 32'(hit), 32'd1);
    check_output("map31", 32'(alive_map[31]), 32'd0);
    apply_stimulus(5'd16, 4'd1, 1'b1); tick();
    check_output("origin_hit", 32'(hit), 32'd1);
    check_output("count29", 32'(alive_count), 32'd29);
    apply_stimulus(5'd0, 4'd0, 1'b0);
    #1 reset = 1'b1;
    #1;
    check_output("async_hit", 32'(hit), 32'd0);
    check_output("async_x", 32'(fleet_x), 32'd0);
    check_output("async_y", 32'(fleet_y), 32'd0);
    check_output("async_count", 32'(alive_count), 32'd32);
    tick();
    reset = 1'b0;
    tick();

    // Wipe out the whole fleet at origin (0,0)
    start = 1'b1; tick(); start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        apply_stimulus(5'(2*c), 4'(r), 1'b1);
        tick();
        check_output($sformatf("kill_r%0d_c%0d", r, c), 32'(hit), 32'd1);
      end
    end
    apply_stimulus(5'd0, 4'd0, 1'b0);
    check_output("count0", 32'(alive_count), 32'd0);
    tick();
    check_output("cleared", 32'(fleet_cleared), 32'd1);
    run_enable(8);
    check_output("cleared_nomarch", 32'(fleet_x), 32'd0);
    check_output("cleared_hold", 32'(fleet_cleared), 32'd1);
    clear = 1'b1; tick(); clear = 1'b0;
    check_output("clear_idle", 32'(fleet_cleared), 32'd0);
    check_output("clear_count", 32'(alive_count), 32'd32);

    start = 1'b1; tick(); start = 1'b0;
    apply_stimulus(5'd0, 4'd0, 1'b1);
    clear = 1'b1; tick(); clear = 1'b0;
    check_output("clear_beats_hit", 32'(hit), 32'd0);
    check_output("clear_map", alive_map, 32'hFFFF_FFFF);
    tick();
    check_output("post_clear_idle", 32'(hit), 32'd0);
    apply_stimulus(5'd0, 4'd0, 1'b0);

    // Full fleet lands when fleet_y reaches 10 (row 3 at 13)
    start = 1'b1; tick(); start = 1'b0;
    run_enable(179*4);
    check_output("pre_land_y", 32'(fleet_y), 32'd9);
    check_output("pre_land_x", 32'(fleet_x), 32'd0);
    check_output("pre_land_inv", 32'(invaded), 32'd0);
    run_enable(4);
    tick();
    check_output("land_y", 32'(fleet_y), 32'd10);
    check_output("land_inv", 32'(invaded), 32'd1);
    run_enable(80);
    check_output("land_hold_y", 32'(fleet_y), 32'd10);

    // Row 3 dead: lowest live row is 2, so landing at fleet_y = 11
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      apply_stimulus(5'(2*c), 4'd3, 1'b1);
      tick();
    end
    apply_stimulus(5'd0, 4'd0, 1'b0);
    check_output("row3_dead", 32'(alive_map[31:24]), 32'd0);
    check_output("row3_count", 32'(alive_count), 32'd24);
    run_enable(197*4);
    tick();
    check_output("r3_pre_y", 32'(fleet_y), 32'd10);
    check_output("r3_pre_x", 32'(fleet_x), 32'd17);
    check_output("r3_pre_inv", 32'(invaded), 32'd0);
    run_enable(4);
    tick();
    check_output("r3_land_y", 32'(fleet_y), 32'd11);
    check_output("r3_land_inv", 32'(invaded), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
